// File: rtl/brs_operand_loader.sv
// Operand sequencer: assembles byte pairs from a valid/ready byte stream into
// A/B operands for the XOR/AND stage, drops stale A on timeout, counts pairs.
module brs_operand_loader #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       op_a,
    output logic [7:0]       op_b,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             timeout_err,
    output logic [CNT_W-1:0] pair_count
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         op_a_q, op_a_d;
    logic [7:0]         op_b_q, op_b_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]   pair_count_q, pair_count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= LOAD_A;
            op_a_q        <= 8'h00;
            op_b_q        <= 8'h00;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
            pair_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            timer_q       <= timer_d;
            timeout_err_q <= timeout_err_d;
            pair_count_q  <= pair_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        timer_d       = timer_q;
        timeout_err_d = 1'b0;
        pair_count_d  = pair_count_q;

        case (state_q)
            LOAD_A: begin
                if (in_valid) begin
                    op_a_d  = in_data;
                    timer_d = '0;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (in_valid) begin
                    // A byte on the expiry cycle still completes the pair
                    op_b_d  = in_data;
                    state_d = PRESENT;
                end else begin
                    if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                        state_d       = LOAD_A;
                        timeout_err_d = 1'b1;
                    end
                    if (timer_q != TMR_W'(TIMEOUT)) begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            PRESENT: begin
                if (op_ready) begin
                    state_d      = LOAD_A;
                    pair_count_d = pair_count_q + CNT_W'(1);
                end
            end
            default: state_d = LOAD_A;
        endcase
    end

    assign in_ready    = (state_q != PRESENT);
    assign op_valid    = (state_q == PRESENT);
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign timeout_err = timeout_err_q;
    assign pair_count  = pair_count_q;

endmodule

// File: tb/tb_brs_operand_loader.sv
// Scoreboard bench for brs_operand_loader: transaction-level driver pushes
// expected pairs / timeout events; a negedge monitor pops and compares.
module tb_brs_operand_loader;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       op_a;
    logic [7:0]       op_b;
    logic             op_valid;
    logic             op_ready;
    logic             timeout_err;
    logic [CNT_W-1:0] pair_count;

    brs_operand_loader #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .timeout_err (timeout_err),
        .pair_count  (pair_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
    } pair_t;

    pair_t            pair_q[$];
    int               err_q[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc    = 0;
    logic [CNT_W-1:0] exp_count = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Downstream stage: bit 7 of A selects AND, otherwise XOR
    function automatic logic [7:0] stage_c(input logic [7:0] a, input logic [7:0] b);
        return a[7] ? (a & b) : (a ^ b);
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            chk("pair_count", 32'(pair_count), 32'(exp_count));
            if (op_valid && op_ready) begin
                if (pair_q.size() == 0) begin
                    fail_now("unexpected_pair");
                end else begin
                    pair_t p;
                    p = pair_q.pop_front();
                    chk("op_a", 32'(op_a), 32'(p.a));
                    chk("op_b", 32'(op_b), 32'(p.b));
                    chk("stage_c", 32'(stage_c(op_a, op_b)), 32'(stage_c(p.a, p.b)));
                end
            end
            if (timeout_err) begin
                if (err_q.size() == 0) begin
                    fail_now("unexpected_timeout_err");
                end else begin
                    chk("timeout_cycle", 32'(cyc), 32'(err_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input int gap, input int hold);
        pair_q.push_back('{a: a, b: b});
        in_valid = 1'b1;
        in_data  = a;
        op_ready = 1'($urandom);
        chk("in_ready_a", 32'(in_ready), 32'd1);
        tick();
        op_ready = 1'b0;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            chk("op_valid_loadb", 32'(op_valid), 32'd0);
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        chk("in_ready_b", 32'(in_ready), 32'd1);
        tick();
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            chk("hold_valid", 32'(op_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_op_a", 32'(op_a), 32'(a));
            chk("hold_op_b", 32'(op_b), 32'(b));
            tick();
        end
        op_ready = 1'b1;
        in_valid = 1'($urandom);
        in_data  = 8'($urandom);
        chk("present_valid", 32'(op_valid), 32'd1);
        tick();
        exp_count = exp_count + CNT_W'(1);
        op_ready  = 1'b0;
        in_valid  = 1'b0;
        chk("released_valid", 32'(op_valid), 32'd0);
    endtask

    task automatic send_orphan(input logic [7:0] a, input int idle);
        in_valid = 1'b1;
        in_data  = a;
        chk("in_ready_orphan", 32'(in_ready), 32'd1);
        tick();
        err_q.push_back(cyc + int'(TIMEOUT));
        for (int i = 0; i < idle; i++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            op_ready = 1'($urandom);
            tick();
        end
        op_ready = 1'b0;
        chk("after_timeout_in_ready", 32'(in_ready), 32'd1);
        chk("after_timeout_valid", 32'(op_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        op_ready = 1'b0;
        #2;
        chk("rst_op_valid", 32'(op_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_op_a", 32'(op_a), 32'd0);
        chk("rst_op_b", 32'(op_b), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_pair_count", 32'(pair_count), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        send_pair(8'h35, 8'h0F, 0, 0);
        chk("count_after_first", 32'(pair_count), 32'd1);
        send_pair(8'h81, 8'hC3, 0, 5);
        chk("count_after_held", 32'(pair_count), 32'd2);
        send_orphan(8'h81, TIMEOUT);
        send_pair(8'h22, 8'h11, 0, 0);
        send_pair(8'h5A, 8'h55, TIMEOUT - 1, 0);

        // Wrap: 256 deliveries bring the counter back around
        for (int n = 0; n < 256; n++) begin
            send_pair(8'($urandom), 8'($urandom), $urandom_range(0, TIMEOUT - 1), $urandom_range(0, 2));
            if (exp_count == 8'hFF) chk("wrap_ff", 32'(pair_count), 32'hFF);
            if (exp_count == 8'h00) chk("wrap_00", 32'(pair_count), 32'h00);
        end

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 4) == 0)
                send_orphan(8'($urandom), $urandom_range(TIMEOUT, TIMEOUT + 3));
            else
                send_pair(8'($urandom), 8'($urandom), $urandom_range(0, TIMEOUT - 1), $urandom_range(0, 3));
        end

        // Mid-cycle reset while presenting a pair
        in_valid = 1'b1;
        in_data  = 8'h7E;
        tick();
        in_data  = 8'h3C;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(op_valid), 32'd1);
        chk("pre_rst_op_a", 32'(op_a), 32'h7E);
        #2;
        rst       = 1'b1;
        exp_count = '0;
        #1;
        chk("mid_rst_op_valid", 32'(op_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_op_a", 32'(op_a), 32'd0);
        chk("mid_rst_op_b", 32'(op_b), 32'd0);
        chk("mid_rst_pair_count", 32'(pair_count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        send_pair(8'hA5, 8'h96, 1, 1);
        chk("post_rst_count", 32'(pair_count), 32'd1);

        repeat (TIMEOUT + 2) tick();
        chk("pairs_drained", 32'(pair_q.size()), 32'd0);
        chk("errs_drained", 32'(err_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
